// File: rtl/ss_sg_arb_pkg.sv
// ---------------------------------------------------------------------------
// ss_sg_arb_pkg
// Shared definitions for the ss_sg channel arbiter/sequencer:
//   - FSM state encoding (IDLE/LOAD/KICK/WAIT/RESP/ERR)
//   - ss_sg engine register map and control values
//   - bit position of the bus-error flag in sg_state
//   - helper for the modulo-NCH round-robin pointer advance
// ---------------------------------------------------------------------------
package ss_sg_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_KICK = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    // Engine register map
    localparam logic [1:0]  SS_ADR_NEXT   = 2'b00;
    localparam logic [1:0]  SS_ADR_CTRL   = 2'b01;
    localparam logic [31:0] SS_CTRL_START = 32'h1;

    // sg_state bit that flags a bus error
    localparam int SG_STATE_ERR = 0;

    // Descriptor pointers carry address bits [31:3]
    localparam int PTR_W  = 29;
    // Channel indices are 3 bits wide, so at most 8 channels
    localparam int MAX_CH = 8;

    // Advance a channel index, wrapping explicitly at nch-1 so that
    // non-power-of-two channel counts work.
    function automatic logic [2:0] next_idx(input logic [2:0] idx, input int nch);
        return (int'(idx) == nch - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/ss_sg_arb_rr.sv
// ---------------------------------------------------------------------------
// ss_rr_arb
// Combinational round-robin pick: returns the first requester at or after
// rr_ptr_i, wrapping modulo NCH.
// Ports:
//   req_i     [NCH-1:0]  request vector
//   rr_ptr_i  [2:0]      highest-priority index (must be < NCH)
//   any_o                at least one request present
//   idx_o     [2:0]      selected index (0 when any_o is low)
// ---------------------------------------------------------------------------
module ss_rr_arb
    import ss_sg_arb_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] req_i,
    input  logic [2:0]     rr_ptr_i,
    output logic           any_o,
    output logic [2:0]     idx_o
);

    // Requests padded to the full 3-bit index range so any candidate
    // index is a legal select.
    logic [MAX_CH-1:0] req_pad;
    logic [2:0]        cand [NCH];

    assign req_pad = MAX_CH'(req_i);

    // cand[gi] is the channel at priority position gi (0 = highest).
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
            logic [3:0] sum;
            assign sum      = {1'b0, rr_ptr_i} + 4'(gi);
            assign cand[gi] = (sum >= 4'(NCH)) ? 3'(sum - 4'(NCH)) : sum[2:0];
        end
    endgenerate

    // Walk from lowest to highest priority so the highest-priority
    // requester overwrites the rest.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req_pad[cand[k]]) begin
                idx_o = cand[k];
            end
        end
    end

endmodule

// File: rtl/ss_sg_arb.sv
// ---------------------------------------------------------------------------
// ss_sg_arb
// Round-robin arbiter and sequencer sharing one ss_sg descriptor engine
// among NCH DMA channels. Grants a channel, writes its next pointer and a
// start command to the engine, waits for the result (with watchdog), and
// returns the fetched fields to the granted channel.
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   ch_req / ch_next          per-channel request and descriptor pointer
//   ch_gnt / ch_vld / ch_err  one-hot pulses: grant, result valid, abort
//   ch_desc/ch_addr/ch_nxt    last successfully fetched result
//   busy, cur_ch              engine owned, granted channel index
//   ss_we/ss_adr/ss_dat       engine register write port
//   ss_ready, ss_done         result handshake and engine release
//   ss_xfer, sg_*             engine result pulse and fields
//
// Timing: every output is a register loaded while the FSM sits in the
// state it belongs to, so each phase becomes visible one cycle after the
// state register enters it (grant, then LOAD write, then KICK write, then
// ss_ready). WAIT therefore only evaluates exits once ss_ready is visible,
// which keeps ss_xfer sampling aligned with what the engine observes.
// ---------------------------------------------------------------------------
module ss_sg_arb
    import ss_sg_arb_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 10
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NCH-1:0]       ch_req,
    input  logic [NCH*PTR_W-1:0] ch_next,
    output logic [NCH-1:0]       ch_gnt,
    output logic [NCH-1:0]       ch_vld,
    output logic [NCH-1:0]       ch_err,
    output logic [15:0]          ch_desc,
    output logic [PTR_W-1:0]     ch_addr,
    output logic [PTR_W-1:0]     ch_nxt,
    output logic                 busy,
    output logic [2:0]           cur_ch,
    output logic                 ss_we,
    output logic [1:0]           ss_adr,
    output logic [31:0]          ss_dat,
    output logic                 ss_ready,
    output logic                 ss_done,
    input  logic                 ss_xfer,
    input  logic [7:0]           sg_state,
    input  logic [15:0]          sg_desc,
    input  logic [PTR_W-1:0]     sg_addr,
    input  logic [PTR_W-1:0]     sg_next
);

    state_e             state_q, state_d;
    logic [2:0]         rr_q, rr_d;
    logic [2:0]         cur_q, cur_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NCH-1:0]     gnt_q, gnt_d;
    logic [NCH-1:0]     vld_q, vld_d;
    logic [NCH-1:0]     err_q, err_d;
    logic [15:0]        desc_q, desc_d;
    logic [PTR_W-1:0]   addr_q, addr_d;
    logic [PTR_W-1:0]   nxt_q, nxt_d;
    logic               busy_q, busy_d;
    logic               we_q, we_d;
    logic [1:0]         adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic               pick_any;
    logic [2:0]         pick_idx;
    logic [PTR_W-1:0]   next_arr [MAX_CH];
    logic               bus_err;
    logic               unused_state;

    assign bus_err      = sg_state[SG_STATE_ERR];
    assign unused_state = ^sg_state[7:1];

    // Per-channel pointers, padded to 8 entries so cur_q always selects
    // a defined value.
    generate
        for (genvar gi = 0; gi < MAX_CH; gi++) begin : g_next
            if (gi < NCH) begin : g_used
                assign next_arr[gi] = ch_next[PTR_W*gi +: PTR_W];
            end else begin : g_pad
                assign next_arr[gi] = '0;
            end
        end
    endgenerate

    ss_rr_arb #(
        .NCH (NCH)
    ) u_rr (
        .req_i    (ch_req),
        .rr_ptr_i (rr_q),
        .any_o    (pick_any),
        .idx_o    (pick_idx)
    );

    function automatic logic [NCH-1:0] onehot(input logic [2:0] idx);
        return {{(NCH-1){1'b0}}, 1'b1} << idx;
    endfunction

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cur_d   = cur_q;
        timer_d = timer_q;
        gnt_d   = '0;
        vld_d   = '0;
        err_d   = '0;
        desc_d  = desc_q;
        addr_d  = addr_q;
        nxt_d   = nxt_q;
        busy_d  = busy_q;
        we_d    = 1'b0;
        adr_d   = SS_ADR_NEXT;
        dat_d   = '0;
        ready_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    cur_d   = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                we_d    = 1'b1;
                adr_d   = SS_ADR_NEXT;
                dat_d   = {next_arr[cur_q], 3'b000};
                state_d = ST_LOAD == state_q ? ST_KICK : state_q;
            end
            ST_KICK: begin
                we_d    = 1'b1;
                adr_d   = SS_ADR_CTRL;
                dat_d   = SS_CTRL_START;
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                ready_d = 1'b1;
                // First WAIT cycle still shows the KICK write; exits are
                // only taken once ss_ready is on the port.
                if (ready_q) begin
                    timer_d = timer_q + 1'b1;
                    if (ss_xfer && !bus_err) begin
                        // Success wins even against a simultaneous timeout.
                        desc_d  = sg_desc;
                        addr_d  = sg_addr;
                        nxt_d   = sg_next;
                        vld_d   = onehot(cur_q);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b0;
                        state_d = ST_RESP;
                    end else if (bus_err || (timer_q == TW'(TIMEOUT - 1))) begin
                        err_d   = onehot(cur_q);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b0;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_RESP, ST_ERR: begin
                rr_d    = next_idx(cur_q, NCH);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            cur_q   <= '0;
            timer_q <= '0;
            gnt_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            desc_q  <= '0;
            addr_q  <= '0;
            nxt_q   <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cur_q   <= cur_d;
            timer_q <= timer_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            desc_q  <= desc_d;
            addr_q  <= addr_d;
            nxt_q   <= nxt_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ch_gnt   = gnt_q;
    assign ch_vld   = vld_q;
    assign ch_err   = err_q;
    assign ch_desc  = desc_q;
    assign ch_addr  = addr_q;
    assign ch_nxt   = nxt_q;
    assign busy     = busy_q;
    assign cur_ch   = cur_q;
    assign ss_we    = we_q;
    assign ss_adr   = adr_q;
    assign ss_dat   = dat_q;
    assign ss_ready = ready_q;
    assign ss_done  = done_q;

endmodule
